// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR pseudo-random source:
//   - drawState_e : states of the bounded-draw engine
//   - defaultTaps : maximal-length Fibonacci feedback masks for widths 4..32
//   - boundMask   : smallest all-ones mask that covers the range [0, bound)
// No ports; imported by lfsr_core and lfsr_prng.
// ---------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_RESP = 2'd2
    } drawState_e;

    // Bit i set means state[i] feeds the XOR. Every entry has bit width-1 set,
    // so the register always shifts its top bit into the feedback.
    function automatic logic [31:0] defaultTaps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_D008;
        endcase
        return taps;
    endfunction

    // mask = 2^k - 1 with k = ceil(log2(bound)). Smearing the top set bit of
    // (bound - 1) downwards gives exactly that; bound 1 yields 0, bound 0 is
    // treated as the full range.
    function automatic logic [31:0] boundMask(input logic [31:0] bound);
        logic [31:0] v;
        if (bound == 32'd0) begin
            v = '1;
        end else begin
            v = bound - 32'd1;
            for (int i = 1; i < 32; i = i * 2) begin
                v = v | (v >> i);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// ---------------------------------------------------------------------------
// lfsr_core
// Fibonacci LFSR state register with seed loading and zero-seed substitution.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   step_en_i       advance the state one step (ignored while a seed loads)
//   seed_valid_i    load seed_i this cycle (takes priority over stepping)
//   seed_i          seed value; zero is replaced by SEED
//   state_o         current state (registered)
//   next_o          the value the state would step to (combinational)
//   lockup_o        one-cycle pulse after a zero seed was replaced
// ---------------------------------------------------------------------------
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(defaultTaps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_en_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] next_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_q, lockup_d;
    logic             feedback;
    logic [WIDTH-1:0] stepped;

    // One shift step plus the load/step priority. A zero seed would freeze
    // the register forever, so it is swapped for SEED and flagged instead.
    always_comb begin
        feedback = ^(state_q & TAPS);
        stepped  = {state_q[WIDTH-2:0], feedback};
        state_d  = state_q;
        lockup_d = 1'b0;
        if (seed_valid_i) begin
            if (seed_i == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed_i;
            end
        end else if (step_en_i) begin
            state_d = stepped;
        end
    end

    // State and lockup flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    assign state_o  = state_q;
    assign next_o   = stepped;
    assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_prng.sv
// ---------------------------------------------------------------------------
// lfsr_prng
// Pseudo-random source: free-running LFSR word plus a bounded-draw engine that
// returns a uniform value in [0, bound) by rejection sampling.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   next_i             step the LFSR (ignored while a draw is running)
//   seed_valid_i/seed_i  load a seed (zero becomes SEED, lockup_o pulses)
//   rand_o             current LFSR state
//   lockup_o           zero-seed substitution pulse
//   req_valid_i/req_ready_o/req_bound_i       draw request (bound 0 = full range)
//   rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_fallback_o  draw response
// ---------------------------------------------------------------------------
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(defaultTaps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int unsigned      MAX_TRIES = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             next_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] rand_o,
    output logic             lockup_o,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_bound_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_fallback_o
);

    localparam int unsigned        TRIES_W     = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] MAX_TRIES_C = TRIES_W'(MAX_TRIES);

    drawState_e         state_q, state_d;
    logic [WIDTH-1:0]   bound_q, bound_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [WIDTH-1:0]   rspData_q, rspData_d;
    logic               rspFallback_q, rspFallback_d;

    logic [WIDTH-1:0]   lfsrNext;
    logic [TRIES_W-1:0] triesInc;
    logic [WIDTH-1:0]   candidate;
    logic               stepEn;

    // While drawing the engine owns the LFSR and steps it every cycle, so
    // next_i only matters when idle or holding a response.
    assign stepEn = (state_q == ST_DRAW) || next_i;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .step_en_i    (stepEn),
        .seed_valid_i (seed_valid_i),
        .seed_i       (seed_i),
        .state_o      (rand_o),
        .next_o       (lfsrNext),
        .lockup_o     (lockup_o)
    );

    // Draw engine. The candidate is taken from the value the LFSR steps to
    // this cycle, so the registered response matches rand_o after the step.
    // A seed load stalls the draw: no step, no try consumed. The fallback
    // subtraction stays in range because the mask is below 2*bound.
    always_comb begin
        state_d       = state_q;
        bound_d       = bound_q;
        mask_d        = mask_q;
        tries_d       = tries_q;
        rspData_d     = rspData_q;
        rspFallback_d = rspFallback_q;
        triesInc      = tries_q + TRIES_W'(1);
        candidate     = lfsrNext & mask_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    bound_d = req_bound_i;
                    mask_d  = WIDTH'(boundMask(32'(req_bound_i)));
                    tries_d = '0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (!seed_valid_i) begin
                    tries_d = triesInc;
                    if ((bound_q == '0) || (candidate < bound_q)) begin
                        rspData_d     = candidate;
                        rspFallback_d = 1'b0;
                        state_d       = ST_RESP;
                    end else if (triesInc == MAX_TRIES_C) begin
                        rspData_d     = candidate - bound_q;
                        rspFallback_d = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine registers; reset drops any draw or response in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            bound_q       <= '0;
            mask_q        <= '0;
            tries_q       <= '0;
            rspData_q     <= '0;
            rspFallback_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bound_q       <= bound_d;
            mask_q        <= mask_d;
            tries_q       <= tries_d;
            rspData_q     <= rspData_d;
            rspFallback_q <= rspFallback_d;
        end
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_data_o     = rspData_q;
    assign rsp_fallback_o = rspFallback_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// ---------------------------------------------------------------------------
// tb_lfsr_prng
// Drives two lfsr_prng instances (MAX_TRIES 16 and 1) with shared stimulus and
// compares both against a behavioural model every cycle, plus literal checks
// of known sequences and draw results.
// ---------------------------------------------------------------------------
module tb_lfsr_prng;

    localparam logic [31:0] TAPS_C = 32'h0000_D008;
    localparam int M_IDLE = 0;
    localparam int M_DRAW = 1;
    localparam int M_RESP = 2;

    logic        clk;
    logic        rstN;
    logic        nextIn;
    logic        seedValid;
    logic [15:0] seedIn;
    logic        reqValid;
    logic [15:0] reqBound;
    logic        rspReady;

    logic [15:0] rand0, rand1, data0, data1;
    logic        lockup0, lockup1, ready0, ready1, valid0, valid1, fb0, fb1;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 0;

    typedef struct {
        int unsigned lfsr;
        int          mode;
        int unsigned bound;
        int          tries;
        int unsigned data;
        bit          fb;
        bit          lock;
    } mdl_t;

    mdl_t mdl [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lfsr_prng #(.WIDTH(16), .TAPS(16'hD008), .SEED(16'h0001), .MAX_TRIES(16)) dut (
        .clk_i(clk), .rst_ni(rstN), .next_i(nextIn),
        .seed_valid_i(seedValid), .seed_i(seedIn),
        .rand_o(rand0), .lockup_o(lockup0),
        .req_valid_i(reqValid), .req_ready_o(ready0), .req_bound_i(reqBound),
        .rsp_valid_o(valid0), .rsp_ready_i(rspReady),
        .rsp_data_o(data0), .rsp_fallback_o(fb0)
    );

    lfsr_prng #(.WIDTH(16), .TAPS(16'hD008), .SEED(16'h0001), .MAX_TRIES(1)) dutFb (
        .clk_i(clk), .rst_ni(rstN), .next_i(nextIn),
        .seed_valid_i(seedValid), .seed_i(seedIn),
        .rand_o(rand1), .lockup_o(lockup1),
        .req_valid_i(reqValid), .req_ready_o(ready1), .req_bound_i(reqBound),
        .rsp_valid_o(valid1), .rsp_ready_i(rspReady),
        .rsp_data_o(data1), .rsp_fallback_o(fb1)
    );

    // Parity of the tapped bits shifted in at the bottom.
    function automatic int unsigned stepVal(int unsigned s);
        int unsigned fbBit;
        fbBit = $countones(s & TAPS_C) % 2;
        return ((s << 1) | fbBit) & 32'h0000_FFFF;
    endfunction

    // Smallest power of two that is >= b.
    function automatic int unsigned span(int unsigned b);
        int unsigned p;
        p = 1;
        while (p < b) p = p * 2;
        return p;
    endfunction

    function automatic mdl_t resetModel();
        mdl_t r;
        r.lfsr = 1; r.mode = M_IDLE; r.bound = 0; r.tries = 0;
        r.data = 0; r.fb = 0; r.lock = 0;
        return r;
    endfunction

    // One clock of the behavioural model for an engine with maxT tries.
    function automatic mdl_t advance(mdl_t s, int maxT);
        mdl_t        n;
        int unsigned nxt;
        int unsigned cand;
        n = s;
        n.lock = seedValid && (seedIn == 16'h0);
        if (s.mode == M_DRAW) begin
            if (seedValid) begin
                n.lfsr = (seedIn == 16'h0) ? 1 : seedIn;
            end else begin
                nxt     = stepVal(s.lfsr);
                n.lfsr  = nxt;
                n.tries = s.tries + 1;
                cand    = (s.bound == 0) ? nxt : (nxt % span(s.bound));
                if (s.bound == 0 || cand < s.bound) begin
                    n.data = cand; n.fb = 0; n.mode = M_RESP;
                end else if (n.tries == maxT) begin
                    n.data = cand - s.bound; n.fb = 1; n.mode = M_RESP;
                end
            end
        end else begin
            if (seedValid) n.lfsr = (seedIn == 16'h0) ? 1 : seedIn;
            else if (nextIn) n.lfsr = stepVal(s.lfsr);
            if (s.mode == M_IDLE && reqValid) begin
                n.mode = M_DRAW; n.bound = reqBound; n.tries = 0;
            end else if (s.mode == M_RESP && rspReady) begin
                n.mode = M_IDLE;
            end
        end
        return n;
    endfunction

    // Model state follows the DUT clock and asynchronous reset.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mdl[0] <= resetModel();
            mdl[1] <= resetModel();
        end else begin
            mdl[0] <= advance(mdl[0], 16);
            mdl[1] <= advance(mdl[1], 1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit sv, input logic [15:0] sd, input bit nx,
                                 input bit rv, input logic [15:0] bd, input bit rr);
        seedValid = sv; seedIn = sd; nextIn = nx;
        reqValid = rv; reqBound = bd; rspReady = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    // Compare both instances against the model on every falling edge.
    task automatic compareDut(input int i);
        logic [15:0] r, d;
        logic        lk, rd, vl, f;
        r  = (i == 0) ? rand0   : rand1;
        d  = (i == 0) ? data0   : data1;
        lk = (i == 0) ? lockup0 : lockup1;
        rd = (i == 0) ? ready0  : ready1;
        vl = (i == 0) ? valid0  : valid1;
        f  = (i == 0) ? fb0     : fb1;
        checkOutput($sformatf("dut%0d.rand_o", i), 32'(r), mdl[i].lfsr);
        checkOutput($sformatf("dut%0d.lockup_o", i), 32'(lk), 32'(mdl[i].lock));
        checkOutput($sformatf("dut%0d.req_ready_o", i), 32'(rd), 32'(mdl[i].mode == M_IDLE));
        checkOutput($sformatf("dut%0d.rsp_valid_o", i), 32'(vl), 32'(mdl[i].mode == M_RESP));
        if (mdl[i].mode == M_RESP) begin
            checkOutput($sformatf("dut%0d.rsp_data_o", i), 32'(d), mdl[i].data);
            checkOutput($sformatf("dut%0d.rsp_fallback_o", i), 32'(f), 32'(mdl[i].fb));
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) compareDut(i);
        end
    end

    // Directed literal checks followed by a randomized run.
    initial begin
        int steps;
        int sel;
        logic [15:0] bnd;

        rstN = 1'b0;
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        applyReset();
        checking = 1;

        checkOutput("reset.rand_o", 32'(rand0), 32'h1);
        checkOutput("reset.req_ready_o", 32'(ready0), 32'h1);
        checkOutput("reset.rsp_valid_o", 32'(valid0), 32'h0);
        checkOutput("reset.rsp_data_o", 32'(data0), 32'h0);
        checkOutput("reset.rsp_fallback_o", 32'(fb0), 32'h0);
        checkOutput("reset.lockup_o", 32'(lockup0), 32'h0);

        // Known start of the sequence, then the full period.
        applyStimulus(0, 16'h0, 1, 0, 16'h0, 1);
        tick(); checkOutput("seq.step1", 32'(rand0), 32'h0002);
        tick(); checkOutput("seq.step2", 32'(rand0), 32'h0004);
        tick(); checkOutput("seq.step3", 32'(rand0), 32'h0008);
        tick(); checkOutput("seq.step4", 32'(rand0), 32'h0011);
        steps = 4;
        while (steps < 70000) begin
            tick();
            steps++;
            if (rand0 == 16'h0001) break;
        end
        checkOutput("seq.period", 32'(steps), 32'd65535);

        // Seed loads with and without zero substitution.
        applyStimulus(1, 16'h1234, 0, 0, 16'h0, 1);
        tick();
        checkOutput("seed.rand_o", 32'(rand0), 32'h1234);
        checkOutput("seed.lockup_o", 32'(lockup0), 32'h0);
        applyStimulus(1, 16'h0000, 0, 0, 16'h0, 1);
        tick();
        checkOutput("zeroseed.rand_o", 32'(rand0), 32'h0001);
        checkOutput("zeroseed.lockup_o", 32'(lockup0), 32'h1);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        tick();
        checkOutput("zeroseed.lockup_end", 32'(lockup0), 32'h0);

        // Full-range draw from reset: one cycle to respond.
        applyReset();
        applyStimulus(0, 16'h0, 0, 1, 16'h0, 1);
        tick();
        checkOutput("draw0.ready_busy", 32'(ready0), 32'h0);
        checkOutput("draw0.valid_early", 32'(valid0), 32'h0);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        tick();
        checkOutput("draw0.valid", 32'(valid0), 32'h1);
        checkOutput("draw0.data", 32'(data0), 32'h2);
        checkOutput("draw0.fallback", 32'(fb0), 32'h0);
        tick();
        checkOutput("draw0.ready_again", 32'(ready0), 32'h1);

        // Bound 3 from reset: candidate 2 accepted.
        applyReset();
        applyStimulus(0, 16'h0, 0, 1, 16'd3, 1);
        tick();
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        tick();
        checkOutput("draw3.valid", 32'(valid0), 32'h1);
        checkOutput("draw3.data", 32'(data0), 32'h2);

        // Single-try instance: seed 7, bound 5 -> candidate 6 rejected, fallback 1.
        applyReset();
        applyStimulus(1, 16'h0007, 0, 0, 16'h0, 1);
        tick();
        checkOutput("fb.seed", 32'(rand1), 32'h7);
        applyStimulus(0, 16'h0, 0, 1, 16'd5, 1);
        tick();
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        tick();
        checkOutput("fb.valid", 32'(valid1), 32'h1);
        checkOutput("fb.data", 32'(data1), 32'h1);
        checkOutput("fb.fallback", 32'(fb1), 32'h1);
        checkOutput("fb.main_still_drawing", 32'(valid0), 32'h0);

        // Reset while one engine draws and the other holds a response.
        rstN = 1'b0;
        #1;
        checkOutput("midrst.rand_o", 32'(rand0), 32'h1);
        checkOutput("midrst.req_ready_o", 32'(ready0), 32'h1);
        checkOutput("midrst.rsp_valid_o", 32'(valid1), 32'h0);
        checkOutput("midrst.rsp_data_o", 32'(data1), 32'h0);
        checkOutput("midrst.rsp_fallback_o", 32'(fb1), 32'h0);
        tick();
        rstN = 1'b1;

        // Seed load during DRAW stalls without consuming the single try.
        applyStimulus(1, 16'h0007, 0, 0, 16'h0, 1);
        tick();
        applyStimulus(0, 16'h0, 0, 1, 16'd5, 1);
        tick();
        applyStimulus(1, 16'h0007, 0, 0, 16'h0, 1);
        tick();
        checkOutput("stall.valid", 32'(valid1), 32'h0);
        checkOutput("stall.rand_o", 32'(rand1), 32'h7);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        tick();
        checkOutput("stall.resp_valid", 32'(valid1), 32'h1);
        checkOutput("stall.resp_data", 32'(data1), 32'h1);
        checkOutput("stall.resp_fallback", 32'(fb1), 32'h1);

        // Back-pressure: response held while next_i keeps stepping the LFSR.
        applyReset();
        applyStimulus(0, 16'h0, 0, 1, 16'h0, 0);
        tick();
        applyStimulus(0, 16'h0, 1, 0, 16'h0, 0);
        tick();
        checkOutput("hold.valid", 32'(valid0), 32'h1);
        checkOutput("hold.rand_draw", 32'(rand0), 32'h2);
        checkOutput("hold.data1", 32'(data0), 32'h2);
        applyStimulus(0, 16'h0, 1, 0, 16'h0, 0);
        tick();
        checkOutput("hold.rand_a", 32'(rand0), 32'h4);
        checkOutput("hold.data2", 32'(data0), 32'h2);
        checkOutput("hold.ready", 32'(ready0), 32'h0);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 0);
        tick();
        checkOutput("hold.rand_b", 32'(rand0), 32'h4);
        applyStimulus(0, 16'h0, 1, 0, 16'h0, 0);
        tick();
        checkOutput("hold.rand_c", 32'(rand0), 32'h8);
        checkOutput("hold.data3", 32'(data0), 32'h2);
        checkOutput("hold.valid_end", 32'(valid0), 32'h1);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        tick();
        checkOutput("hold.released", 32'(ready0), 32'h1);

        // Randomized traffic against the model, with one reset in the middle.
        applyReset();
        for (int c = 0; c < 4000; c++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       bnd = 16'h0;
                1:       bnd = 16'($urandom_range(1, 8));
                2:       bnd = 16'($urandom_range(1, 300));
                default: bnd = 16'($urandom_range(1, 16'hFFFF));
            endcase
            applyStimulus($urandom_range(0, 15) == 0,
                          ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) != 0,
                          bnd,
                          $urandom_range(0, 3) != 0);
            if (c == 2000) begin
                rstN = 1'b0;
                tick();
                rstN = 1'b1;
            end else begin
                tick();
            end
        end

        applyStimulus(0, 16'h0, 0, 0, 16'h0, 1);
        tick();
        tick();
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
